jt51_acc_seq: RTL and testbench

Slot sequencer and channel-configuration scheduler for the JT51 output accumulator. It runs the 32-slot operator frame counter and emits the per-slot group markers (`m1_enters`, `m2_enters`, `c1_enters`, `c2_enters`) and the `op31_acc` flag. It also holds the per-channel pan (`rl`) and connection (`con`) settings and presents them aligned with each slot. Configuration writes from the register interface are double-buffered and committed only at a frame boundary, so the accumulator never sees a channel change mid-frame.

---
 rtl/jt51_seq_pkg.sv | 23 ++
 rtl/jt51_cfg_bank.sv | 60 ++++++
 rtl/jt51_acc_seq.sv | 99 +++++++++
 tb/tb_jt51_acc_seq.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/jt51_seq_pkg.sv
// Shared constants and types for the JT51 accumulator slot sequencer.
// Slot index is {group[1:0], ch[2:0]}.
package jt51_seq_pkg;

    localparam int SLOTS    = 32;
    localparam int CHANNELS = 8;

    localparam logic [4:0] COMMIT_SLOT = 5'd31;
    localparam logic [4:0] STROBE_SLOT = 5'd16;

    typedef enum logic [1:0] {
        GRP_M1 = 2'd0,
        GRP_M2 = 2'd1,
        GRP_C1 = 2'd2,
        GRP_C2 = 2'd3
    } grp_e;

    typedef struct packed {
        logic [1:0] rl;
        logic [2:0] con;
    } cfg_t;

endpackage

// File: rtl/jt51_cfg_bank.sv
// Double-buffered per-channel {rl, con} table: writes land in the shadow
// copy and are copied to the live copy as a whole on commit.
module jt51_cfg_bank
    import jt51_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en_i,
    input  logic [2:0] wr_ch_i,
    input  logic [4:0] wr_cfg_i,
    input  logic       commit_i,
    input  logic [2:0] rd_idx_i,
    output logic [4:0] rd_cfg_o,
    output logic       pending_o
);

    cfg_t shadow_q [CHANNELS];
    cfg_t shadow_d [CHANNELS];
    cfg_t live_q   [CHANNELS];
    cfg_t live_d   [CHANNELS];
    logic pending_q, pending_d;

    always_comb begin
        shadow_d = shadow_q;
        if (wr_en_i) begin
            shadow_d[wr_ch_i] = cfg_t'(wr_cfg_i);
        end
        live_d = live_q;
        if (commit_i) begin
            live_d = shadow_d;
        end
        pending_d = pending_q;
        if (commit_i) begin
            pending_d = 1'b0;
        end else if (wr_en_i) begin
            pending_d = 1'b1;
        end
    end

    // Bypass on commit so the first slot of a new frame already sees the
    // freshly committed entry, including a write landing on that same cycle.
    always_comb begin
        rd_cfg_o = commit_i ? shadow_d[rd_idx_i] : live_q[rd_idx_i];
    end

    assign pending_o = pending_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_q  <= '{default: '0};
            live_q    <= '{default: '0};
            pending_q <= 1'b0;
        end else begin
            shadow_q  <= shadow_d;
            live_q    <= live_d;
            pending_q <= pending_d;
        end
    end

endmodule

// File: rtl/jt51_acc_seq.sv
// 32-slot frame sequencer for the JT51 accumulator: group markers, op31 flag,
// sample strobe and frame-aligned per-channel pan/connection.
module jt51_acc_seq
    import jt51_seq_pkg::*;
(
    input  logic       rst,
    input  logic       clk,
    input  logic       cen,
    input  logic       resync,
    input  logic       wr_en,
    input  logic [2:0] wr_ch,
    input  logic [1:0] wr_rl,
    input  logic [2:0] wr_con,
    output logic [4:0] slot,
    output logic       m1_enters,
    output logic       m2_enters,
    output logic       c1_enters,
    output logic       c2_enters,
    output logic       op31_acc,
    output logic [1:0] rl_I,
    output logic [2:0] con_I,
    output logic       sample_stb,
    output logic       cfg_pending
);

    logic [4:0] cnt_q, cnt_d;
    logic       commit;
    logic [4:0] rd_cfg_raw;
    cfg_t       rd_cfg;

    logic [4:0] slot_q;
    logic       m1_q, m2_q, c1_q, c2_q, op31_q, stb_q;
    logic [1:0] rl_q;
    logic [2:0] con_q;

    // cnt starts at 31 so the first cen both enters slot 0 and commits.
    always_comb begin
        cnt_d  = cnt_q;
        commit = 1'b0;
        if (cen) begin
            cnt_d  = resync ? 5'd0 : cnt_q + 5'd1;
            commit = resync || (cnt_q == COMMIT_SLOT);
        end
    end

    jt51_cfg_bank u_cfg_bank (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (wr_en),
        .wr_ch_i   (wr_ch),
        .wr_cfg_i  ({wr_rl, wr_con}),
        .commit_i  (commit),
        .rd_idx_i  (cnt_d[2:0]),
        .rd_cfg_o  (rd_cfg_raw),
        .pending_o (cfg_pending)
    );

    assign rd_cfg = cfg_t'(rd_cfg_raw);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= COMMIT_SLOT;
            slot_q <= 5'd0;
            m1_q   <= 1'b0;
            m2_q   <= 1'b0;
            c1_q   <= 1'b0;
            c2_q   <= 1'b0;
            op31_q <= 1'b0;
            stb_q  <= 1'b0;
            rl_q   <= 2'd0;
            con_q  <= 3'd0;
        end else begin
            stb_q <= 1'b0;
            if (cen) begin
                cnt_q  <= cnt_d;
                slot_q <= cnt_d;
                m1_q   <= (cnt_d[4:3] == GRP_M1);
                m2_q   <= (cnt_d[4:3] == GRP_M2);
                c1_q   <= (cnt_d[4:3] == GRP_C1);
                c2_q   <= (cnt_d[4:3] == GRP_C2);
                op31_q <= (cnt_d == COMMIT_SLOT);
                stb_q  <= (cnt_d == STROBE_SLOT);
                rl_q   <= rd_cfg.rl;
                con_q  <= rd_cfg.con;
            end
        end
    end

    assign slot       = slot_q;
    assign m1_enters  = m1_q;
    assign m2_enters  = m2_q;
    assign c1_enters  = c1_q;
    assign c2_enters  = c2_q;
    assign op31_acc   = op31_q;
    assign sample_stb = stb_q;
    assign rl_I       = rl_q;
    assign con_I      = con_q;

endmodule

// File: tb/tb_jt51_acc_seq.sv
// Self-checking bench for jt51_acc_seq: directed scenarios followed by random
// traffic, all compared against a frame-level reference model.
module tb_jt51_acc_seq;

    logic       clk = 1'b0;
    logic       rst, cen, resync, wr_en;
    logic [2:0] wr_ch;
    logic [1:0] wr_rl;
    logic [2:0] wr_con;
    logic [4:0] slot;
    logic       m1_enters, m2_enters, c1_enters, c2_enters, op31_acc;
    logic [1:0] rl_I;
    logic [2:0] con_I;
    logic       sample_stb, cfg_pending;

    always #5 clk = ~clk;

    jt51_acc_seq dut (
        .rst         (rst),
        .clk         (clk),
        .cen         (cen),
        .resync      (resync),
        .wr_en       (wr_en),
        .wr_ch       (wr_ch),
        .wr_rl       (wr_rl),
        .wr_con      (wr_con),
        .slot        (slot),
        .m1_enters   (m1_enters),
        .m2_enters   (m2_enters),
        .c1_enters   (c1_enters),
        .c2_enters   (c2_enters),
        .op31_acc    (op31_acc),
        .rl_I        (rl_I),
        .con_I       (con_I),
        .sample_stb  (sample_stb),
        .cfg_pending (cfg_pending)
    );

    // Reference model: frame position plus shadow/live channel tables.
    int pos;
    int grp;
    int sh_rl [8], sh_con [8], lv_rl [8], lv_con [8];
    int e_slot, e_op31, e_stb, e_rl, e_con, e_pend;
    int n_cmp = 0;
    int n_bad = 0;
    int stb_seen = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        pos = 31;
        grp = -1;
        for (int i = 0; i < 8; i++) begin
            sh_rl[i] = 0; sh_con[i] = 0; lv_rl[i] = 0; lv_con[i] = 0;
        end
        e_slot = 0; e_op31 = 0; e_stb = 0; e_rl = 0; e_con = 0; e_pend = 0;
    endtask

    task automatic check_all();
        chk("slot", 32'(slot), e_slot);
        chk("m1_enters", 32'(m1_enters), (grp == 0) ? 1 : 0);
        chk("m2_enters", 32'(m2_enters), (grp == 1) ? 1 : 0);
        chk("c1_enters", 32'(c1_enters), (grp == 2) ? 1 : 0);
        chk("c2_enters", 32'(c2_enters), (grp == 3) ? 1 : 0);
        chk("op31_acc", 32'(op31_acc), e_op31);
        chk("sample_stb", 32'(sample_stb), e_stb);
        chk("rl_I", 32'(rl_I), e_rl);
        chk("con_I", 32'(con_I), e_con);
        chk("cfg_pending", 32'(cfg_pending), e_pend);
    endtask

    // One clk: drive at negedge, update model at posedge, check 1 time unit later.
    task automatic cyc(input bit c, input bit rs, input bit we, input int ch,
                       input int rl, input int con, input bit r);
        @(negedge clk);
        rst = r; cen = c; resync = rs; wr_en = we;
        wr_ch = 3'(ch); wr_rl = 2'(rl); wr_con = 3'(con);
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            if (we) begin
                sh_rl[ch] = rl; sh_con[ch] = con; e_pend = 1;
            end
            if (c) begin
                if (rs || pos == 31) begin
                    lv_rl = sh_rl; lv_con = sh_con; e_pend = 0;
                end
                pos    = rs ? 0 : (pos + 1) % 32;
                grp    = pos / 8;
                e_slot = pos;
                e_op31 = (pos == 31) ? 1 : 0;
                e_stb  = (pos == 16) ? 1 : 0;
                e_rl   = lv_rl[pos % 8];
                e_con  = lv_con[pos % 8];
            end else begin
                e_stb = 0;
            end
        end
        #1;
        if (sample_stb === 1'b1) stb_seen++;
        check_all();
    endtask

    task automatic tick();
        cyc(1, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic run_to(input int target);
        int guard = 0;
        while (pos != target && guard < 64) begin
            tick();
            guard++;
        end
        chk("run_to_reached", pos, target);
    endtask

    initial begin
        rst = 1'b1; cen = 1'b0; resync = 1'b0; wr_en = 1'b0;
        wr_ch = '0; wr_rl = '0; wr_con = '0;
        model_reset();

        // Reset with a write and cen asserted: write must be dropped.
        cyc(1, 0, 1, 2, 3, 6, 1);
        cyc(0, 0, 0, 0, 0, 0, 1);
        chk("reset_slot", 32'(slot), 0);
        chk("reset_pending", 32'(cfg_pending), 0);

        // Full frame plus one.
        stb_seen = 0;
        for (int i = 0; i < 33; i++) tick();
        chk("frame_stb_count", stb_seen, 1);
        chk("frame_wrap_slot", 32'(slot), 0);

        // Write ch3 mid-frame; must not become visible until the next frame.
        run_to(10);
        cyc(1, 0, 1, 3, 3, 5, 0);
        chk("ch3_pending", 32'(cfg_pending), 1);
        chk("ch3_slot11_rl_old", 32'(rl_I), 0);
        chk("ch3_slot11_con_old", 32'(con_I), 0);
        run_to(31);
        tick();
        chk("ch3_committed_pending", 32'(cfg_pending), 0);
        run_to(3);
        chk("ch3_slot3_rl", 32'(rl_I), 3);
        chk("ch3_slot3_con", 32'(con_I), 5);
        run_to(27);
        chk("ch3_slot27_con", 32'(con_I), 5);

        // Write exactly on the commit cycle.
        run_to(31);
        cyc(1, 0, 1, 0, 0, 7, 0);
        chk("commit_edge_con", 32'(con_I), 7);
        chk("commit_edge_pending", 32'(cfg_pending), 0);

        // cen 1-in-3.
        for (int i = 0; i < 40; i++) begin
            cyc(0, 0, 0, 0, 0, 0, 0);
            cyc(0, 0, 0, 0, 0, 0, 0);
            tick();
        end

        // resync at slot 20 with a pending write.
        run_to(18);
        cyc(1, 0, 1, 6, 1, 2, 0);
        run_to(20);
        cyc(1, 1, 0, 0, 0, 0, 0);
        chk("resync_slot", 32'(slot), 0);
        chk("resync_pending", 32'(cfg_pending), 0);
        stb_seen = 0;
        run_to(6);
        chk("resync_ch6_rl", 32'(rl_I), 1);
        chk("resync_ch6_con", 32'(con_I), 2);
        run_to(15);
        chk("resync_no_early_stb", stb_seen, 0);

        // Reset mid-frame with ch5 write pending.
        run_to(11);
        cyc(1, 0, 1, 5, 3, 4, 0);
        cyc(1, 0, 1, 5, 2, 1, 1);
        chk("rst_mid_pending", 32'(cfg_pending), 0);
        chk("rst_mid_slot", 32'(slot), 0);
        run_to(5);
        chk("rst_ch5_rl", 32'(rl_I), 0);
        chk("rst_ch5_con", 32'(con_I), 0);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            cyc(1'($urandom_range(0, 2) != 0),
                1'($urandom_range(0, 39) == 0),
                1'($urandom_range(0, 3) == 0),
                int'($urandom_range(0, 7)),
                int'($urandom_range(0, 3)),
                int'($urandom_range(0, 7)),
                1'($urandom_range(0, 199) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
